// File: rtl/imem_boot_pkg.sv
// Shared states and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CSUM,
        RUN,
        ERR
    } boot_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int RESET_WADDR    = 0;

    // An image length is usable when it is non-empty and fits the memory budget.
    function automatic logic hdr_len_ok(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (32'(n) <= 32'(max_words));
    endfunction

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Big-endian byte-to-word packer: each accepted byte shifts in at the low end.
module boot_word_packer
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] byte_cnt;

    assign word_full = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory and holds MIPS_SC in reset.
// Optional trailer checksum byte is enabled by defining IMEM_BOOT_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, core held in reset, waiting for load_start
// HDR_HI | accept word-count high byte
// HDR_LO | accept word-count low byte, validate length
// DATA   | accept data bytes into the packer
// WRITE  | one-cycle instruction-memory write
// CSUM   | accept and compare the XOR trailer byte
// RUN    | image loaded, core released
// ERR    | load rejected, core held in reset
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    if (MAX_WORDS > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("MAX_WORDS exceeds instruction memory depth");
    end

    boot_state_e       state, state_n;
    logic [7:0]        n_hi;
    logic [15:0]       n_full;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] addr;
    logic              xfer;
    logic              last_word;
    logic              hdr_ok;
    logic              pk_clear;
    logic              pk_shift;
    logic              pk_full;
    logic [31:0]       pk_word;

    assign xfer      = byte_valid && byte_ready;
    assign n_full    = {n_hi, byte_data};
    assign hdr_ok    = hdr_len_ok(n_full, MAX_WORDS);
    assign last_word = (words_left == 16'd1);
    assign pk_clear  = (state == HDR_LO) && xfer;
    assign pk_shift  = (state == DATA) && xfer;

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_match;

    assign csum_match = (csum == byte_data);

    // Running XOR restarts whenever no load is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if ((state == IDLE) || (state == RUN) || (state == ERR)) begin
            csum <= '0;
        end else if (xfer && (state != CSUM)) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

    boot_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .byte_in   (byte_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (load_start) state_n = HDR_HI;
            end
            HDR_HI: begin
                if (xfer) state_n = HDR_LO;
            end
            HDR_LO: begin
                if (xfer) state_n = hdr_ok ? DATA : ERR;
            end
            DATA: begin
                if (pk_full) state_n = WRITE;
            end
            WRITE: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state_n = last_word ? CSUM : DATA;
`else
                state_n = last_word ? RUN : DATA;
`endif
            end
            CSUM: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (xfer) state_n = csum_match ? RUN : ERR;
`else
                state_n = ERR;
`endif
            end
            RUN, ERR: begin
                if (load_start) state_n = HDR_HI;
            end
            default: state_n = IDLE;
        endcase
    end

    // Length, address and count bookkeeping; words_left counts down to the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_hi       <= '0;
            words_left <= '0;
            addr       <= ADDR_W'(RESET_WADDR);
            word_count <= '0;
        end else begin
            if ((state == HDR_HI) && xfer) begin
                n_hi <= byte_data;
            end
            if ((state == HDR_LO) && xfer && hdr_ok) begin
                words_left <= n_full;
                addr       <= ADDR_W'(RESET_WADDR);
                word_count <= '0;
            end
            if (state == WRITE) begin
                words_left <= words_left - 16'd1;
                addr       <= addr + ADDR_W'(1);
                word_count <= word_count + 16'd1;
            end
        end
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            byte_ready <= (state_n == HDR_HI) || (state_n == HDR_LO) ||
                          (state_n == DATA)   || (state_n == CSUM);
            imem_we    <= (state_n == WRITE);
            busy       <= (state_n == HDR_HI) || (state_n == HDR_LO) ||
                          (state_n == DATA)   || (state_n == WRITE)  ||
                          (state_n == CSUM);
            done       <= (state_n == RUN);
            err        <= (state_n == ERR);
            cpu_reset  <= (state_n != RUN);
        end
    end

    assign imem_waddr = addr;
    assign imem_wdata = pk_word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a stream-level reference model.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 64;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       word_count;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int fall_cyc = 0;
    logic cpu_rst_prev = 1'b1;
    logic [ADDR_W-1:0] wq_a[$];
    logic [31:0]       wq_d[$];
    int last_wc = 0;

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write capture and release timing, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            wq_a.push_back(imem_waddr);
            wq_d.push_back(imem_wdata);
            last_we_cyc = cyc;
            chk("ready_in_write", 32'(byte_ready), 32'd0);
        end
        if (cpu_rst_prev === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
        cpu_rst_prev = cpu_reset;
    end

    function automatic logic [7:0] xor_of(input bq_t s);
        logic [7:0] x = 8'h00;
        foreach (s[i]) x ^= s[i];
        return x;
    endfunction

    // Appends the trailer byte when the checksum build is selected.
    function automatic bq_t finish_stream(input bq_t body, input bit corrupt);
        bq_t s = body;
`ifdef IMEM_BOOT_CHECKSUM_EN
        s.push_back(xor_of(body) ^ (corrupt ? 8'h5A : 8'h00));
`else
        if (corrupt) s = body;
`endif
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_data  = $urandom_range(0, 255);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (byte_ready !== 1'b1) chk("byte_accept_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'd0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    endtask

    // Pulses load_start, streams s, then compares against the reference model.
    task automatic run_load(input string tag, input bq_t s, input int gap_min, input int gap_max,
                            input bit poke_start);
        int         n;
        bit         hdr_ok;
        bit         ok;
        int         exp_wc;
        int         guard;
        int         nsend;
        logic [31:0] ew[$];

        n      = int'({s[0], s[1]});
        hdr_ok = (n >= 1) && (n <= MAX_WORDS);
        ok     = hdr_ok;
        ew     = {};
        if (hdr_ok) begin
            for (int i = 0; i < n; i++)
                ew.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (hdr_ok) ok = (xor_of(s[0:2+4*n-1]) == s[2+4*n]);
`endif
        exp_wc = hdr_ok ? n : last_wc;
        nsend  = hdr_ok ? s.size() : 2;

        wq_a = {};
        wq_d = {};
        fall_cyc = 0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk({tag, "_start_busy"}, 32'(busy), 32'd1);
        chk({tag, "_start_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_start_flags"}, 32'({done, err}), 32'd0);

        for (int i = 0; i < nsend; i++) begin
            if (poke_start && i == 3) load_start = 1'b1;
            send_byte(s[i], $urandom_range(gap_min, gap_max));
            load_start = 1'b0;
        end

        guard = 0;
        while (done !== 1'b1 && err !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_settle_timeout"}, 32'(guard == 50), 32'd0);
        @(negedge clk);

        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_err"}, 32'(err), 32'(!ok));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
        chk({tag, "_nwrites"}, 32'(wq_d.size()), 32'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq_d.size(); i++) begin
            chk({tag, "_waddr"}, 32'(wq_a[i]), 32'(i));
            chk({tag, "_wdata"}, wq_d[i], ew[i]);
        end
        if (ok) chk({tag, "_release_delay"}, 32'(fall_cyc - last_we_cyc), 32'd1);
        last_wc = exp_wc;
    endtask

    initial begin
        bq_t s;
        int  n;

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("idle");

        // Directed two-word image.
        s = finish_stream('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'hAC, 8'h08, 8'h00, 8'h04}, 1'b0);
        run_load("two_word", s, 0, 0, 1'b0);

        // Rejected headers, then recovery.
        run_load("hdr_zero", '{8'h00, 8'h00}, 0, 0, 1'b0);
        run_load("hdr_65", '{8'h00, 8'h41}, 0, 0, 1'b0);
        s = finish_stream('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'hAC, 8'h08, 8'h00, 8'h04}, 1'b0);
        run_load("recover", s, 0, 0, 1'b0);

        // Same image with byte_valid toggling every other cycle.
        run_load("toggle", s, 1, 1, 1'b0);

        // Boundary image length of exactly MAX_WORDS.
        s = '{8'h00, 8'(MAX_WORDS)};
        for (int i = 0; i < 4 * MAX_WORDS; i++) s.push_back($urandom_range(0, 255));
        run_load("max_len", finish_stream(s, 1'b0), 0, 0, 1'b0);

        // Reset in the middle of a load.
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wq_d = {};
        s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (s[i]) send_byte(s[i], 0);
        chk("midrst_partial_write", wq_d.size() > 0 ? wq_d[0] : 32'hDEAD_BEEF, 32'h11223344);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        last_wc = 0;
        @(negedge clk);
        s = finish_stream('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0);
        run_load("after_rst", s, 0, 1, 1'b0);

        // Reload from RUN with a one-word image.
        s = finish_stream('{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C}, 1'b0);
        run_load("reload", s, 0, 0, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        run_load("csum_good", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 0, 0, 1'b0);
        run_load("csum_bad", '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00}, 0, 0, 1'b0);
`endif

        // Randomized images, including rejected lengths and ignored mid-load starts.
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = $urandom_range(MAX_WORDS + 1, 400);
                default: n = $urandom_range(1, 6);
            endcase
            s = '{8'(n >> 8), 8'(n)};
            if (n >= 1 && n <= MAX_WORDS) begin
                for (int i = 0; i < 4 * n; i++) s.push_back($urandom_range(0, 255));
                s = finish_stream(s, $urandom_range(0, 3) == 0);
            end
            run_load("rand", s, 0, 2, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader upstream of the single-cycle MIPS core (MIPS_SC).
- Receives a length-prefixed, big-endian byte stream and packs it into 32-bit instructions, which it writes sequentially into instruction memory from word address 0.
- Holds the core in reset until the whole image is written, then releases it so execution starts at PC 0.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- MAX_WORDS, 64, largest image accepted; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- load_start  in  1  one-cycle pulse; begins a new load.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts byte_data this cycle (transfer = valid & ready).
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  active-high reset to MIPS_SC.
- busy  out  1  load in progress.
- done  out  1  image loaded, core running.
- err  out  1  load rejected.
- word_count  out  16  words written in current/last load.

Behaviour:
- Reset (reset=0, async): state IDLE; cpu_reset=1; all other outputs 0; word_count=0; byte counter and address cleared.
- Stream format:
  - 2 header bytes N[15:8], N[7:0].
  - Then N words, each 4 bytes, MSB first: first byte -> bits 31:24.
- States:
  - IDLE: byte_ready=0, cpu_reset=1. load_start -> HDR_HI.
  - HDR_HI: byte_ready=1. On transfer, latch N high byte -> HDR_LO.
  - HDR_LO: byte_ready=1. On transfer, form N.
    - N==0 or N>MAX_WORDS -> ERR.
    - Otherwise clear word_count and address -> DATA.
  - DATA: byte_ready=1. Shift bytes into the packer; on the 4th byte transfer -> WRITE.
  - WRITE: byte_ready=0. imem_we=1 for exactly this cycle, at imem_waddr, with imem_wdata. Increment address and word_count.
    - word_count+1==N -> RUN (or CSUM if enabled).
    - Otherwise -> DATA.
  - RUN: cpu_reset=0, done=1, busy=0.
  - ERR: err=1, cpu_reset=1, byte_ready=0.
- Timing:
  - imem_we asserts the cycle after the 4th byte of a word transfers.
  - cpu_reset falls the cycle after the last WRITE.
- Registered outputs:
  - busy=1 in HDR_HI, HDR_LO, DATA, WRITE (and CSUM).
  - done and err are mutually exclusive.
- load_start in RUN or ERR:
  - -> HDR_HI, cpu_reset=1, done=0, err=0; word_count is held until the header completes.
- load_start while busy: ignored.
- byte_valid while byte_ready=0: not consumed; upstream holds the byte.
- Address wraps naturally at 2**ADDR_W. Unreachable while MAX_WORDS <= 2**ADDR_W.
- reset asserted mid-load: immediate return to IDLE. Partial image left in memory; core stays in reset.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to CSUM (byte_ready=1) and accept one trailer byte.
  - Running XOR covers all header and data bytes.
  - Trailer equal to the XOR -> RUN; mismatch -> ERR.
- Undefined: no CSUM state; no trailer byte; last WRITE -> RUN directly.

Decomposition:
- Package imem_boot_pkg:
  - state enum (IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, RUN, ERR);
  - HDR_BYTES=2, BYTES_PER_WORD=4;
  - MIPS reset-vector constant RESET_WADDR=0.
- Sub-module boot_word_packer:
  - 32-bit shift-left-by-8 register plus 2-bit byte counter;
  - outputs word and a word_full strobe;
  - cleared by the FSM on header completion.

Test Plan:
- Reset, then load_start with stream 00 02 | 20 08 00 05 | AC 08 00 04 -> two writes: addr0=0x20080005, addr1=0xAC080004. cpu_reset falls the cycle after the 2nd write; done=1, word_count=2.
- Header 00 00, then header 00 41 (MAX_WORDS=64) -> err=1, no imem_we, cpu_reset stays 1. A following load_start with a valid stream recovers to done.
- Same 2-word image with byte_valid toggled every other cycle -> identical memory contents. No byte lost or duplicated; byte_ready=0 during WRITE cycles.
- reset driven low after 5 data bytes -> all outputs at reset values immediately, cpu_reset=1. New load writes from addr 0.
- In RUN, pulse load_start and send a 1-word image 00 01 | 00 00 00 0C -> cpu_reset re-asserts next cycle. addr0=0x0000000C, then RUN again.
- With IMEM_BOOT_CHECKSUM_EN, 1-word image 00 01 | 12 34 56 78:
  - trailer 0x09 -> done;
  - trailer 0x00 -> err, cpu_reset=1.
